// File: rtl/posit_stream_accumulator_if.sv
// Stream-in, adder-side and result-out signals of the posit stream accumulator.
// slave is the accumulator's view; master is the surrounding logic's view.
interface posit_stream_accumulator_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [N-1:0] add_in1;
    logic [N-1:0] add_in2;
    logic         add_start;
    logic [N-1:0] add_result;
    logic         add_inf;
    logic [N-1:0] m_data;
    logic         m_inf;
    logic         m_valid;
    logic         m_ready;

    modport slave (
        input  s_data, s_valid, s_last, add_result, add_inf, m_ready,
        output s_ready, add_in1, add_in2, add_start, m_data, m_inf, m_valid
    );

    modport master (
        output s_data, s_valid, s_last, add_result, add_inf, m_ready,
        input  s_ready, add_in1, add_in2, add_start, m_data, m_inf, m_valid
    );
endinterface

// File: rtl/posit_stream_accumulator.sv
// Reduces a posit packet to one sum by recirculating results through an external
// LAT-cycle pipelined adder, then tree-reducing the in-flight partials at end of packet.
module posit_stream_accumulator #(
    parameter int unsigned N   = 8,
    parameter int unsigned es  = 4,
    parameter int unsigned LAT = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    posit_stream_accumulator_if.slave   io
);
    localparam int unsigned LW = $clog2(LAT + 1) + 1;

    // The attached adder must be built for the same format.
    if (es + 2 > N) begin : g_es_check
        $error("posit_stream_accumulator: es too large for N");
    end

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

    state_t         state, state_nx;
    logic [LAT-1:0] vpipe;
    logic [LW-1:0]  live, live_nx;
    logic [N-1:0]   hold, hold_nx;
    logic           hold_v, hold_v_nx;
    logic           sticky, sticky_nx;
    logic           s_ready_q;
    logic           m_valid_q;
    logic           fb;
    logic           fire;
    logic [N-1:0]   add_in1_c, add_in2_c;
    logic           add_start_c;

    assign fb   = vpipe[LAT-1];
    assign fire = io.s_valid & s_ready_q;

    // Next state, partial bookkeeping and adder issue.
    always_comb begin
        state_nx    = state;
        live_nx     = live;
        hold_nx     = hold;
        hold_v_nx   = hold_v;
        sticky_nx   = sticky | (fb & io.add_inf);
        add_in1_c   = '0;
        add_in2_c   = '0;
        add_start_c = 1'b0;
        case (state)
            ACCUM: begin
                if (fire) add_in1_c = io.s_data;
                if (fb)   add_in2_c = io.add_result;
                add_start_c = fire | fb;
                if (fire & ~fb)       live_nx  = live + LW'(1);
                if (fire & io.s_last) state_nx = DRAIN;
            end
            DRAIN: begin
                // Pair each emerging partial with the held one; the last survivor is the sum.
                if (fb & ~hold_v) begin
                    hold_nx   = io.add_result;
                    hold_v_nx = 1'b1;
                    if (live == LW'(1)) state_nx = OUT;
                end else if (fb & hold_v) begin
                    add_in1_c   = hold;
                    add_in2_c   = io.add_result;
                    add_start_c = 1'b1;
                    hold_v_nx   = 1'b0;
                    live_nx     = live - LW'(1);
                end else if (hold_v && live == LW'(1)) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (io.m_ready) begin
                    hold_v_nx = 1'b0;
                    sticky_nx = 1'b0;
                    live_nx   = '0;
                    state_nx  = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ACCUM;
            vpipe     <= '0;
            live      <= '0;
            hold      <= '0;
            hold_v    <= 1'b0;
            sticky    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state     <= state_nx;
            vpipe     <= {vpipe[LAT-2:0], add_start_c};
            live      <= live_nx;
            hold      <= hold_nx;
            hold_v    <= hold_v_nx;
            sticky    <= sticky_nx;
            s_ready_q <= (state_nx == ACCUM);
            m_valid_q <= (state_nx == OUT);
        end
    end

    assign io.s_ready   = s_ready_q;
    assign io.add_in1   = add_in1_c;
    assign io.add_in2   = add_in2_c;
    assign io.add_start = add_start_c;
    assign io.m_data    = hold;
    assign io.m_inf     = sticky;
    assign io.m_valid   = m_valid_q;
endmodule

// File: tb/tb_posit_stream_accumulator.sv
// Bench for posit_stream_accumulator with a behavioural posit<8,4> adder of latency LAT
// and a queue of expected packet sums.
module tb_posit_stream_accumulator;
    localparam int unsigned N   = 8;
    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       inf;
    } exp_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    posit_stream_accumulator_if #(.N(N)) bus();

    posit_stream_accumulator #(.N(N), .es(4), .LAT(LAT)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .io      (bus)
    );

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int j = 0; j < e; j++) r = r * 2.0;
        else        for (int j = 0; j < -e; j++) r = r / 2.0;
        return r;
    endfunction

    // posit<8,4> decode; NaR is handled by the caller.
    function automatic real pdec(input logic [7:0] p);
        logic [7:0] a;
        int  i, m, k, e;
        real f, w;
        if (p == 8'h00) return 0.0;
        a = p[7] ? 8'(-p) : p;
        m = 0;
        i = 6;
        while (i >= 0) begin
            if (a[3'(i)] != a[6]) break;
            m++;
            i--;
        end
        k = a[6] ? m - 1 : -m;
        i--;
        e = 0;
        for (int j = 0; j < 4; j++) begin
            e = e * 2;
            if (i >= 0) begin
                e += int'(a[3'(i)]);
                i--;
            end
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (a[3'(i)]) f = f + w;
            w = w / 2.0;
            i--;
        end
        return p[7] ? -f * pow2(16 * k + e) : f * pow2(16 * k + e);
    endfunction

    // Nearest code, ties to the even code; exact rounding for the magnitudes used here.
    function automatic logic [7:0] penc(input real x);
        real        ax, best, d, v;
        logic [7:0] bc;
        if (x == 0.0) return 8'h00;
        ax   = (x < 0.0) ? -x : x;
        bc   = 8'h01;
        best = -1.0;
        for (int c = 1; c < 128; c++) begin
            v = pdec(8'(c));
            d = (v > ax) ? v - ax : ax - v;
            if (best < 0.0 || d < best || (d == best && (c % 2) == 0)) begin
                best = d;
                bc   = 8'(c);
            end
        end
        return (x < 0.0) ? 8'(-bc) : bc;
    endfunction

    // Behavioural pipelined adder; not reset, so stale results keep flowing after a reset.
    logic [7:0] pd   [LAT] = '{default: 8'h00};
    logic       pinf [LAT] = '{default: 1'b0};
    logic       pv   [LAT] = '{default: 1'b0};

    always @(posedge aclk) begin
        if (bus.add_in1 == 8'h80 || bus.add_in2 == 8'h80) begin
            pd[0]   <= 8'h80;
            pinf[0] <= 1'b1;
        end else begin
            pd[0]   <= penc(pdec(bus.add_in1) + pdec(bus.add_in2));
            pinf[0] <= 1'b0;
        end
        pv[0] <= bus.add_start;
        for (int i = 1; i < LAT; i++) begin
            pd[i]   <= pd[i-1];
            pinf[i] <= pinf[i-1];
            pv[i]   <= pv[i-1];
        end
    end

    assign bus.add_result = pd[LAT-1];
    assign bus.add_inf    = pinf[LAT-1];

    // Counts additions whose operands are both live partials and tracks outstanding partials.
    logic mon_clr = 1'b0;
    int   outst = 0;
    int   pairs = 0;
    int   peak  = 0;

    always @(negedge aclk) begin
        if (!aresetn || mon_clr) begin
            outst <= 0;
            pairs <= 0;
            peak  <= 0;
        end else begin
            int  o_n;
            bit  fire_m, pair_m;
            fire_m = bus.s_valid && bus.s_ready;
            pair_m = bus.add_start && pv[LAT-1] && (fire_m || !bus.s_ready);
            o_n    = outst + (fire_m ? 1 : 0) - (pair_m ? 1 : 0);
            if (bus.m_valid && bus.m_ready) o_n = 0;
            outst <= o_n;
            pairs <= pairs + (pair_m ? 1 : 0);
            if (o_n > peak) peak <= o_n;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last, output int acc_cyc);
        bit ok = 1'b0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        acc_cyc     = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge aclk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout s_ready=%b required=1", bus.s_ready);
        end
        acc_cyc = cyc;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h00;
    endtask

    task automatic wait_out(output bit ok, output int at_cyc);
        ok     = 1'b0;
        at_cyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (bus.m_valid) begin
                ok     = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL out_timeout m_valid=0 required=1");
        end
    endtask

    task automatic test_reset();
        bit quiet = 1'b1;
        aresetn     = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h40;
        bus.s_last  = 1'b1;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (bus.m_valid !== 1'b0)    begin failures++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.add_start !== 1'b0)  begin failures++; $display("FAIL rst_add_start got=%b exp=0", bus.add_start); end
        checks++; if (bus.s_ready !== 1'b0)    begin failures++; $display("FAIL rst_s_ready got=%b exp=0", bus.s_ready); end
        checks++; if (bus.m_data !== 8'h00)    begin failures++; $display("FAIL rst_m_data got=%h exp=00", bus.m_data); end
        checks++; if (bus.m_inf !== 1'b0)      begin failures++; $display("FAIL rst_m_inf got=%b exp=0", bus.m_inf); end
        checks++; if (bus.add_in1 !== 8'h00 || bus.add_in2 !== 8'h00) begin
            failures++; $display("FAIL rst_add_in got=%h/%h exp=00/00", bus.add_in1, bus.add_in2);
        end
        aresetn = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(negedge aclk);
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL rel_s_ready got=%b exp=1", bus.s_ready); end
        for (int n = 0; n < 8; n++) begin
            if (bus.add_start !== 1'b0 || bus.m_valid !== 1'b0) quiet = 1'b0;
            @(negedge aclk);
        end
        checks++; if (!quiet) begin failures++; $display("FAIL rst_no_accept activity=1 exp=0"); end
        tick();
    endtask

    task automatic test_single();
        int   acc, at;
        bit   ok;
        exp_t e;
        exp_q.push_back('{data: 8'h40, inf: 1'b0});
        send(8'h40, 1'b1, acc);
        wait_out(ok, at);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (bus.m_data !== e.data) begin failures++; $display("FAIL single_data got=%h exp=%h", bus.m_data, e.data); end
            checks++; if (bus.m_inf !== e.inf)   begin failures++; $display("FAIL single_inf got=%b exp=%b", bus.m_inf, e.inf); end
            checks++; if (at - acc != LAT + 1)   begin failures++; $display("FAIL single_latency got=%0d exp=%0d", at - acc, LAT + 1); end
        end
        tick();
    endtask

    task automatic test_gaps();
        bit   pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   sent = 0;
        int   i = 0;
        int   acc, at;
        bit   ok;
        exp_t e;
        mon_clr = 1'b1;
        @(negedge aclk);
        mon_clr = 1'b0;
        tick();
        exp_q.push_back('{data: 8'h46, inf: 1'b0});
        while (sent < 8) begin
            if (pat[i % 5]) begin
                send(8'h40, sent == 7, acc);
                sent++;
            end else begin
                tick();
            end
            i++;
        end
        wait_out(ok, at);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (bus.m_data !== e.data) begin failures++; $display("FAIL gaps_data got=%h exp=%h", bus.m_data, e.data); end
            checks++; if (bus.m_inf !== e.inf)   begin failures++; $display("FAIL gaps_inf got=%b exp=%b", bus.m_inf, e.inf); end
            checks++; if (pairs != 7)            begin failures++; $display("FAIL gaps_pair_adds got=%0d exp=7", pairs); end
            checks++; if (peak > int'(LAT) || peak < 1) begin failures++; $display("FAIL gaps_live_peak got=%0d exp=1..%0d", peak, LAT); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int   acc, at;
        bit   ok;
        exp_t e;
        bus.m_ready = 1'b0;
        exp_q.push_back('{data: 8'h42, inf: 1'b0});
        send(8'h40, 1'b0, acc);
        send(8'h40, 1'b1, acc);
        wait_out(ok, at);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (bus.m_data !== e.data) begin failures++; $display("FAIL stall_data got=%h exp=%h", bus.m_data, e.data); end
            for (int n = 0; n < 10; n++) begin
                @(negedge aclk);
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== e.data || bus.m_inf !== e.inf || bus.s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold cycle=%0d got v=%b d=%h i=%b r=%b exp v=1 d=%h i=%b r=0",
                             n, bus.m_valid, bus.m_data, bus.m_inf, bus.s_ready, e.data, e.inf);
                end
            end
        end
        tick();
        bus.m_ready = 1'b1;
        tick();
        @(negedge aclk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got r=%b v=%b exp r=1 v=0", bus.s_ready, bus.m_valid);
        end
        tick();
    endtask

    task automatic test_sticky();
        int   acc, at;
        bit   ok;
        exp_t e;
        exp_q.push_back('{data: 8'h80, inf: 1'b1});
        send(8'h40, 1'b0, acc);
        send(8'h80, 1'b0, acc);
        send(8'h40, 1'b1, acc);
        wait_out(ok, at);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (bus.m_inf !== e.inf)   begin failures++; $display("FAIL nar_inf got=%b exp=%b", bus.m_inf, e.inf); end
            checks++; if (bus.m_data !== e.data) begin failures++; $display("FAIL nar_data got=%h exp=%h", bus.m_data, e.data); end
        end
        tick();
        exp_q.push_back('{data: 8'h40, inf: 1'b0});
        send(8'h40, 1'b1, acc);
        wait_out(ok, at);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (bus.m_inf !== e.inf)   begin failures++; $display("FAIL sticky_clear got=%b exp=%b", bus.m_inf, e.inf); end
            checks++; if (bus.m_data !== e.data) begin failures++; $display("FAIL sticky_next_data got=%h exp=%h", bus.m_data, e.data); end
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        int   acc, at;
        bit   ok;
        exp_t e;
        for (int n = 0; n < 4; n++) send(8'h40, n == 3, acc);
        tick();
        tick();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        exp_q.push_back('{data: 8'h42, inf: 1'b0});
        send(8'h40, 1'b0, acc);
        send(8'h40, 1'b1, acc);
        wait_out(ok, at);
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (bus.m_data !== e.data) begin failures++; $display("FAIL rst_drain_data got=%h exp=%h", bus.m_data, e.data); end
            checks++; if (bus.m_inf !== e.inf)   begin failures++; $display("FAIL rst_drain_inf got=%b exp=%b", bus.m_inf, e.inf); end
        end
        tick();
    endtask

    initial begin
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        test_reset();
        test_single();
        test_gaps();
        test_backpressure();
        test_sticky();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/posit_stream_accumulator.md
# posit_stream_accumulator

Streaming reduction controller that sits directly upstream of the pipelined `posit_adder_4`. It drives the adder's `in1`/`in2`/`start` and consumes its `result`/`inf`. It accepts a packet of posits on a valid/ready stream and recirculates adder results back into the adder, so each accepted element is issued in the cycle it arrives. At end-of-packet it tree-reduces the in-flight partial sums to one posit and presents it on an output handshake. It is used wherever the PairHMM datapath needs the sum of a variable-length posit stream.

## Interface
- `N`, 8, posit width.
- `es`, 4, exponent size; must match the attached adder.
- `LAT`, 4, adder latency in cycles: `start` at cycle t means `result` is valid at t+LAT.

- `aclk` in 1: the single clock; all state updates on the rising edge.
- `aresetn` in 1: reset; asynchronous, active-low.
- `s_data` in N: input posit.
- `s_valid` in 1: input valid.
- `s_last` in 1: marks the final element of a packet.
- `s_ready` out 1: input accepted when `s_valid & s_ready`.
- `add_in1` out N: adder operand 1.
- `add_in2` out N: adder operand 2.
- `add_start` out 1: issue an addition this cycle.
- `add_result` in N: adder result.
- `add_inf` in 1: adder NaR flag.
- `m_data` out N: packet sum.
- `m_inf` out 1: sticky NaR seen in this packet.
- `m_valid` out 1: output valid.
- `m_ready` in 1: output accepted when `m_valid & m_ready`.

## Operation
- `vpipe[LAT-1:0]`: valid shift register advanced every cycle. Bit 0 is loaded with `add_start`. `fb = vpipe[LAT-1]` means `add_result` carries a live partial this cycle.
- `live`: count of live partial sums, in-flight or held, width ceil(log2(LAT+1))+1.
- `hold`: N-bit register plus a valid bit.
- `sticky`: OR of `add_inf` over every cycle where `fb=1`.
- Adder-side outputs (`add_in1`, `add_in2`, `add_start`) are combinational from state, `fb`, `add_result`, `hold` and `s_*`. Operands not in use are driven to 0, which is posit zero.

States: ACCUM, DRAIN, OUT.

**ACCUM**
- `s_ready=1`.
- `add_in1 = fire ? s_data : 0`, `add_in2 = fb ? add_result : 0`, `add_start = fire | fb`.
- `live` increments when `fire & ~fb`; otherwise it is unchanged.
- On `fire & s_last`, go to DRAIN.

**DRAIN**
- `s_ready=0`.
- If `fb & ~hold_v`: `hold <= add_result`, `hold_v <= 1`, no issue.
- If `fb & hold_v`: issue `add(hold, add_result)`, `hold_v <= 0`, `live <= live-1`.
- When `hold_v & live==1`, go to OUT. `vpipe` is all-zero by construction at that point.

**OUT**
- `m_valid=1`, `m_data=hold`, `m_inf=sticky`.
- On `m_ready`: clear `hold_v`, `sticky` and `live`; return to ACCUM.
- `m_data` and `m_inf` must stay stable while `m_valid & ~m_ready`.

Boundary cases:
- A single-element packet sums with zero. The result is exact (x+0=x).
- Gaps in `s_valid` keep partials recirculating via `add(0, fb)`. No partial is ever dropped.
- `live` never exceeds LAT.
- Reset mid-packet discards all partials. Adder results still in flight from before reset are ignored because `vpipe` is cleared.

## Timing
- Reset values: state=ACCUM, `vpipe=0`, `live=0`, `hold=0`, `hold_v=0`, `sticky=0`.
- Outputs during reset: `s_ready=1` once reset is released (0 while `aresetn=0`); `m_valid=0`, `m_data=0`, `m_inf=0`, `add_start=0`, `add_in1=add_in2=0`.
- Accept throughput: 1 element/cycle in ACCUM.
- DRAIN latency example, LAT=4, 4 live partials emerging at cycles c..c+3:
  - c: hold.
  - c+1: add.
  - c+2: hold.
  - c+3: add.
  - c+5: hold.
  - c+7: add.
  - c+11: hold, `live=1`.
  - c+12: `m_valid=1`.
- Single-element packet: `m_valid` asserts LAT+1 cycles after the accept cycle.
- `s_ready` is 0 from the cycle after `s_last` is accepted until the cycle after the output handshake.

## Test plan
- Reset with `s_valid=1` held: `m_valid=0`, `add_start=0`, `s_ready=0` during reset. `s_ready=1` the first cycle after release. No element is accepted during reset.
- Single element `0x40` (1.0) with `s_last`: `m_data=0x40`, `m_inf=0`, `m_valid` asserted exactly LAT+1=5 cycles after accept.
- 8×`0x40` with `s_valid` toggling 1,0,1,1,0,…: `m_data=0x46` (8.0). `live` peaks at ≤4. Exactly 7 DRAIN+ACCUM pair-additions occur, counting only additions where both operands are live.
- Packet 2×`0x40`, then `m_ready=0` for 10 cycles: `m_valid=1` and `m_data=0x42` held stable throughout, `s_ready=0`. The handshake then returns the block to ACCUM with `s_ready=1`.
- Packet `{0x40, 0x80, 0x40}`, where `0x80` is NaR: `m_inf=1`. Next packet `{0x40}`: `m_inf=0`, confirming the sticky flag clears.
- Assert `aresetn=0` mid-DRAIN, release, then send packet 2×`0x40`: `m_data=0x42` and no stale partial contributes.
